spi_master_ctrl: RTL

Single-byte SPI master that drives the SPI slave stage directly downstream. It generates the serial clock, the active-low `enable` select, the MODE line and MOSI, and captures MISO. It sits between the host-side byte interface and the slave's `internal_clk` / `input_data` / `output_data` / `enable` / `MODE` pins. Frames are exactly 8 bits, LSB first, so the slave's internal bit counter stays aligned.

---
 rtl/spi_pkg.sv | 10 +
 rtl/spi_clk_gen.sv | 40 ++++
 rtl/spi_master_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared constants for the SPI master (mode values, FSM state encoding, frame size).
package spi_pkg;
    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;
    localparam int FRAME_BITS = 8;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;
endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: half-period phase counter; emits sclk plus rise/fall/sample ticks while running.
module spi_clk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic internal_clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    input  logic sclk_en,
    output logic sclk,
    output logic rise_tick,
    output logic fall_tick,
    output logic sample_tick
);
    localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    logic [PW-1:0] phase_q, phase_d;
    logic half_q, half_d, sclk_q, sclk_d, wrap;
    // SETUP counts as a low half, so the first wrap is a rising edge into bit 0
    always_comb begin
        wrap        = run && phase_q == PW'(CLK_DIV - 1);
        rise_tick   = wrap && half_q;
        fall_tick   = wrap && !half_q;
        sample_tick = rise_tick;
        phase_d     = (clear || wrap || !run) ? '0 : phase_q + PW'(1);
        half_d      = clear ? 1'b1 : wrap ? !half_q : half_q;
        sclk_d      = clear ? 1'b0 : rise_tick ? sclk_en : fall_tick ? 1'b0 : sclk_q;
    end
    always_ff @(posedge internal_clk) begin
        if (reset) begin
            phase_q <= '0;
            half_q  <= 1'b1;
            sclk_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            half_q  <= half_d;
            sclk_q  <= sclk_d;
        end
    end
    assign sclk = sclk_q;
endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: single-byte LSB-first SPI master with registered outputs.
// Define SPI_MASTER_LOOPBACK_EN to sample MOSI instead of MISO (rx_data mirrors tx_data).
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic       internal_clk,
    input  logic       reset,
    input  logic       start,
    input  logic       mode,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       done,
    output logic       sclk,
    output logic       enable,
    output logic       MODE,
    output logic       output_data,
    input  logic       input_data
);
    logic [1:0] state_q, state_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] tx_q, tx_d, rx_shift_q, rx_shift_d, rx_q, rx_d;
    logic busy_q, busy_d, done_q, done_d, enable_q, enable_d, mode_q, mode_d, out_q, out_d;
    logic clear, run, sclk_en, last_bit, rise_tick, fall_tick, sample_tick, miso;
`ifdef SPI_MASTER_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = input_data;
    assign miso = out_q;
`else
    assign miso = input_data;
`endif
    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .internal_clk(internal_clk),
        .reset(reset),
        .clear(clear),
        .run(run),
        .sclk_en(sclk_en),
        .sclk(sclk),
        .rise_tick(rise_tick),
        .fall_tick(fall_tick),
        .sample_tick(sample_tick)
    );
    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        tx_d       = tx_q;
        rx_shift_d = rx_shift_q;
        rx_d       = rx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        enable_d   = enable_q;
        mode_d     = mode_q;
        out_d      = out_q;
        clear      = 1'b0;
        run        = state_q != ST_IDLE;
        last_bit   = bit_q == 3'(FRAME_BITS - 1);
        sclk_en    = state_q == ST_SETUP || (state_q == ST_SHIFT && !last_bit);
        if (state_q == ST_IDLE && start) begin
            state_d  = ST_SETUP;
            tx_d     = tx_data;
            mode_d   = mode;
            out_d    = tx_data[0];
            busy_d   = 1'b1;
            enable_d = 1'b0;
            clear    = 1'b1;
        end
        if (state_q == ST_SETUP && rise_tick) state_d = ST_SHIFT;
        // end of a bit's low phase: capture MISO, then advance MOSI to the next bit
        if (state_q == ST_SHIFT && sample_tick) begin
            rx_shift_d[bit_q] = miso;
            bit_d   = last_bit ? 3'd0 : bit_q + 3'd1;
            out_d   = last_bit ? out_q : tx_q[bit_d];
            state_d = last_bit ? ST_HOLD : ST_SHIFT;
        end
        if (state_q == ST_HOLD && fall_tick) begin
            state_d  = ST_IDLE;
            enable_d = 1'b1;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            rx_d     = rx_shift_q;
        end
    end
    always_ff @(posedge internal_clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bit_q      <= '0;
            tx_q       <= '0;
            rx_shift_q <= '0;
            rx_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            enable_q   <= 1'b1;
            mode_q     <= MODE_READ;
            out_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            rx_shift_q <= rx_shift_d;
            rx_q       <= rx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            enable_q   <= enable_d;
            mode_q     <= mode_d;
            out_q      <= out_d;
        end
    end
    assign rx_data     = rx_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign enable      = enable_q;
    assign MODE        = mode_q;
    assign output_data = out_q;
endmodule
